config_chain_loader: RTL

Sequences the serial configuration chain of a logic tile (config_in / config_enable / config_nreset / config_out) from a word-wide host stream. On start it optionally clears the chain, then serialises exactly CHAIN_LENGTH bits, LSB-first, into the tile. It returns the bits that fall out of the chain end as readback words. It sits between the fabric programming interface and one tile's config chain.

---
 rtl/config_chain_loader.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/config_chain_loader.sv
// Serial configuration-chain sequencer for one logic tile: optional chain clear, then an
// LSB-first load of CHAIN_LENGTH bits from a host word stream, with readback of the bits shifted out.
module config_chain_loader #(
  parameter int unsigned CHAIN_LENGTH = 1024,
  parameter int unsigned WORD_WIDTH   = 8,
  parameter int unsigned CLEAR_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear_first,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic [WORD_WIDTH-1:0] rb_data,
  output logic                  rb_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_data,
  output logic                  cfg_enable,
  output logic                  cfg_nreset,
  input  logic                  cfg_return
);

  localparam int unsigned CntW  = $clog2(CHAIN_LENGTH + 1);
  localparam int unsigned WCntW = $clog2(WORD_WIDTH + 1);
  localparam int unsigned ClrW  = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StClear, StLoad, StDone} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]       bits_rem_q, bits_rem_d;
  logic [ClrW-1:0]       clr_cnt_q, clr_cnt_d;
  logic [WORD_WIDTH-1:0] sh_q, sh_d;
  logic [WCntW-1:0]      sh_cnt_q, sh_cnt_d;
  logic [WORD_WIDTH-1:0] rb_sh_q, rb_sh_d;
  logic [WCntW-1:0]      rb_idx_q, rb_idx_d;
  logic [WORD_WIDTH-1:0] rb_data_q, rb_data_d;
  logic                  rb_valid_q, rb_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cfg_data_q, cfg_data_d;
  logic                  cfg_enable_q, cfg_enable_d;
  logic                  cfg_nreset_q, cfg_nreset_d;

  logic                  start_ok;
  logic                  handshake;
  logic [WCntW-1:0]      take_n;

  // cfg_enable_q doubles as "shifter busy": a word is presented on cfg_data while it is high.
  assign word_ready = (state_q == StLoad) && !cfg_enable_q && (bits_rem_q != '0);
  assign handshake  = word_valid && word_ready;
  assign start_ok   = (state_q == StIdle) && start;
  assign take_n     = (32'(bits_rem_q) >= WORD_WIDTH) ? WCntW'(WORD_WIDTH)
                                                      : WCntW'(bits_rem_q);

  assign rb_data    = rb_data_q;
  assign rb_valid   = rb_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cfg_data   = cfg_data_q;
  assign cfg_enable = cfg_enable_q;
  assign cfg_nreset = cfg_nreset_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = clear_first ? StClear : StLoad;
      StClear: if (clr_cnt_q == '0) state_d = StLoad;
      // Leave only once the final word's readback pulse is on the outputs.
      StLoad:  if ((bits_rem_q == '0) && !cfg_enable_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bits_rem_d   = bits_rem_q;
    clr_cnt_d    = clr_cnt_q;
    sh_d         = sh_q;
    sh_cnt_d     = sh_cnt_q;
    rb_sh_d      = rb_sh_q;
    rb_idx_d     = rb_idx_q;
    rb_data_d    = rb_data_q;
    rb_valid_d   = 1'b0;
    done_d       = done_q;
    cfg_data_d   = cfg_data_q;
    cfg_enable_d = cfg_enable_q;
    cfg_nreset_d = cfg_nreset_q;

    if (start_ok) begin
      bits_rem_d   = CntW'(CHAIN_LENGTH);
      clr_cnt_d    = ClrW'(CLEAR_CYCLES - 1);
      cfg_nreset_d = ~clear_first;
      done_d       = 1'b0;
    end

    if (state_q == StClear) begin
      if (clr_cnt_q == '0) begin
        cfg_nreset_d = 1'b1;
      end else begin
        clr_cnt_d = clr_cnt_q - ClrW'(1);
      end
    end

    if (handshake) begin
      // Bit 0 goes straight to cfg_data; the shifter keeps the rest.
      cfg_data_d   = word_data[0];
      cfg_enable_d = 1'b1;
      sh_d         = word_data >> 1;
      sh_cnt_d     = take_n - WCntW'(1);
      bits_rem_d   = bits_rem_q - CntW'(take_n);
      rb_sh_d      = '0;
      rb_idx_d     = '0;
    end else if (cfg_enable_q) begin
      rb_sh_d  = rb_sh_q | (WORD_WIDTH'(cfg_return) << rb_idx_q);
      rb_idx_d = rb_idx_q + WCntW'(1);
      if (sh_cnt_q != '0) begin
        cfg_data_d = sh_q[0];
        sh_d       = sh_q >> 1;
        sh_cnt_d   = sh_cnt_q - WCntW'(1);
      end else begin
        cfg_data_d   = 1'b0;
        cfg_enable_d = 1'b0;
        rb_data_d    = rb_sh_d;
        rb_valid_d   = 1'b1;
      end
    end

    busy_d = (state_d == StClear) || (state_d == StLoad);
    if (state_d == StDone) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bits_rem_q   <= '0;
      clr_cnt_q    <= '0;
      sh_q         <= '0;
      sh_cnt_q     <= '0;
      rb_sh_q      <= '0;
      rb_idx_q     <= '0;
      rb_data_q    <= '0;
      rb_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_data_q   <= 1'b0;
      cfg_enable_q <= 1'b0;
      cfg_nreset_q <= 1'b1;
    end else begin
      bits_rem_q   <= bits_rem_d;
      clr_cnt_q    <= clr_cnt_d;
      sh_q         <= sh_d;
      sh_cnt_q     <= sh_cnt_d;
      rb_sh_q      <= rb_sh_d;
      rb_idx_q     <= rb_idx_d;
      rb_data_q    <= rb_data_d;
      rb_valid_q   <= rb_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cfg_data_q   <= cfg_data_d;
      cfg_enable_q <= cfg_enable_d;
      cfg_nreset_q <= cfg_nreset_d;
    end
  end

endmodule
